// File: rtl/ctrl_pipe.sv
// Pipeline control for a 5-stage MIPS core: carries decoded control through EX/MEM/WB,
// inserts load-use stalls, resolves branches in EX and generates ALU forwarding selects.
module ctrl_pipe #(
  parameter int unsigned RA_W    = 5,
  parameter int unsigned ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RegDst,
  input  logic               ALUSrc,
  input  logic               MemtoReg,
  input  logic               RegWrite,
  input  logic               MemWrite,
  input  logic               ExtOp,
  input  logic [1:0]         Branch,
  input  logic [ALUOP_W-1:0] ALUop,
  input  logic [RA_W-1:0]    id_rs,
  input  logic [RA_W-1:0]    id_rt,
  input  logic [RA_W-1:0]    id_rd,
  input  logic               ex_zero,
  input  logic               ex_neg,
  output logic               stall,
  output logic               flush,
  output logic               pc_sel,
  output logic               ex_ALUSrc,
  output logic               ex_ExtOp,
  output logic [ALUOP_W-1:0] ex_ALUop,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               mem_MemWrite,
  output logic               mem_MemtoReg,
  output logic               wb_RegWrite,
  output logic               wb_MemtoReg,
  output logic [RA_W-1:0]    wb_dst
);

  // EX stage
  logic               ex_alusrc_q, ex_extop_q, ex_memtoreg_q, ex_regwrite_q, ex_memwrite_q;
  logic [1:0]         ex_branch_q;
  logic [ALUOP_W-1:0] ex_aluop_q;
  logic [RA_W-1:0]    ex_rs_q, ex_rt_q, ex_dst_q;
  // MEM stage
  logic               mem_memtoreg_q, mem_regwrite_q, mem_memwrite_q;
  logic [RA_W-1:0]    mem_dst_q;
  // WB stage
  logic               wb_memtoreg_q, wb_regwrite_q;
  logic [RA_W-1:0]    wb_dst_q;

  logic            uses_rt, load_use, taken, bubble;
  logic [RA_W-1:0] id_dst;

  always_comb begin
    uses_rt  = RegDst | MemWrite | (Branch != 2'b00);
    id_dst   = RegDst ? id_rd : id_rt;
    load_use = ex_memtoreg_q & ex_regwrite_q & (ex_dst_q != '0) &
               ((ex_dst_q == id_rs) | (uses_rt & (ex_dst_q == id_rt)));
    unique case (ex_branch_q)
      2'b01:   taken = ex_zero;
      2'b10:   taken = ~ex_zero;
      2'b11:   taken = ~ex_zero & ~ex_neg;
      default: taken = 1'b0;
    endcase
    // A taken branch squashes the ID instruction, so any stall it would need is moot.
    bubble = load_use | taken;
    flush  = taken & ~rst;
    pc_sel = taken & ~rst;
    stall  = load_use & ~taken & ~rst;
  end

  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src,
                                         input logic            mem_we,
                                         input logic [RA_W-1:0] mem_dst,
                                         input logic            wb_we,
                                         input logic [RA_W-1:0] wb_dst_f);
    if (mem_we && (mem_dst != '0) && (mem_dst == src)) begin
      return 2'b10;
    end else if (wb_we && (wb_dst_f != '0) && (wb_dst_f == src)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(ex_rs_q, mem_regwrite_q, mem_dst_q, wb_regwrite_q, wb_dst_q);
    fwd_b = fwd_sel(ex_rt_q, mem_regwrite_q, mem_dst_q, wb_regwrite_q, wb_dst_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_alusrc_q    <= 1'b0;
      ex_extop_q     <= 1'b0;
      ex_memtoreg_q  <= 1'b0;
      ex_regwrite_q  <= 1'b0;
      ex_memwrite_q  <= 1'b0;
      ex_branch_q    <= 2'b00;
      ex_aluop_q     <= '0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_dst_q       <= '0;
      mem_memtoreg_q <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_dst_q      <= '0;
      wb_memtoreg_q  <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_dst_q       <= '0;
    end else begin
      if (bubble) begin
        ex_alusrc_q   <= 1'b0;
        ex_extop_q    <= 1'b0;
        ex_memtoreg_q <= 1'b0;
        ex_regwrite_q <= 1'b0;
        ex_memwrite_q <= 1'b0;
        ex_branch_q   <= 2'b00;
        ex_aluop_q    <= '0;
        ex_rs_q       <= '0;
        ex_rt_q       <= '0;
        ex_dst_q      <= '0;
      end else begin
        ex_alusrc_q   <= ALUSrc;
        ex_extop_q    <= ExtOp;
        ex_memtoreg_q <= MemtoReg;
        ex_regwrite_q <= RegWrite;
        ex_memwrite_q <= MemWrite;
        ex_branch_q   <= Branch;
        ex_aluop_q    <= ALUop;
        ex_rs_q       <= id_rs;
        ex_rt_q       <= id_rt;
        ex_dst_q      <= id_dst;
      end
      mem_memtoreg_q <= ex_memtoreg_q;
      mem_regwrite_q <= ex_regwrite_q;
      mem_memwrite_q <= ex_memwrite_q;
      mem_dst_q      <= ex_dst_q;
      wb_memtoreg_q  <= mem_memtoreg_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_dst_q       <= mem_dst_q;
    end
  end

  assign ex_ALUSrc    = ex_alusrc_q;
  assign ex_ExtOp     = ex_extop_q;
  assign ex_ALUop     = ex_aluop_q;
  assign mem_MemWrite = mem_memwrite_q;
  assign mem_MemtoReg = mem_memtoreg_q;
  assign wb_RegWrite  = wb_regwrite_q;
  assign wb_MemtoReg  = wb_memtoreg_q;
  assign wb_dst       = wb_dst_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: instruction-level pipeline model checked every cycle,
// plus hand-computed spot checks for each scenario.
module tb_ctrl_pipe;

  typedef struct packed {
    logic       rd_sel, alusrc, memtoreg, regwrite, memwrite, extop;
    logic [1:0] br;
    logic [2:0] op;
    logic [4:0] rs, rt, rd;
  } id_t;

  // One in-flight instruction as the model sees it.
  typedef struct packed {
    logic       alusrc, extop, memtoreg, regwrite, memwrite;
    logic [1:0] br;
    logic [2:0] op;
    logic [4:0] rs, rt, dst;
  } ins_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ex_zero = 1'b0, ex_neg = 1'b0;
  id_t  cur = '0;

  logic       stall, flush, pc_sel, ex_ALUSrc, ex_ExtOp, mem_MemWrite, mem_MemtoReg;
  logic       wb_RegWrite, wb_MemtoReg;
  logic [2:0] ex_ALUop;
  logic [1:0] fwd_a, fwd_b;
  logic [4:0] wb_dst;

  int n_chk = 0;
  int n_fail = 0;

  ctrl_pipe #(.RA_W(5), .ALUOP_W(3)) dut (
    .clk(clk), .rst(rst),
    .RegDst(cur.rd_sel), .ALUSrc(cur.alusrc), .MemtoReg(cur.memtoreg),
    .RegWrite(cur.regwrite), .MemWrite(cur.memwrite), .ExtOp(cur.extop),
    .Branch(cur.br), .ALUop(cur.op), .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
    .ex_zero(ex_zero), .ex_neg(ex_neg),
    .stall(stall), .flush(flush), .pc_sel(pc_sel),
    .ex_ALUSrc(ex_ALUSrc), .ex_ExtOp(ex_ExtOp), .ex_ALUop(ex_ALUop),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_MemWrite(mem_MemWrite), .mem_MemtoReg(mem_MemtoReg),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_dst(wb_dst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction builders ----------------
  function automatic id_t mk(logic rd_sel, logic alusrc, logic memtoreg, logic regwrite,
                             logic memwrite, logic extop, logic [1:0] br, logic [2:0] op,
                             logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    id_t w;
    w = '{rd_sel, alusrc, memtoreg, regwrite, memwrite, extop, br, op, rs, rt, rd};
    return w;
  endfunction
  function automatic id_t nop();
    return '0;
  endfunction
  function automatic id_t rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    return mk(1, 0, 0, 1, 0, 0, 2'b00, 3'b010, rs, rt, rd);
  endfunction
  function automatic id_t lw(logic [4:0] rs, logic [4:0] rt);
    return mk(0, 1, 1, 1, 0, 1, 2'b00, 3'b000, rs, rt, 5'd0);
  endfunction
  function automatic id_t sw(logic [4:0] rs, logic [4:0] rt);
    return mk(0, 1, 0, 0, 1, 1, 2'b00, 3'b000, rs, rt, 5'd0);
  endfunction
  function automatic id_t addi(logic [4:0] rs, logic [4:0] rt);
    return mk(0, 1, 0, 1, 0, 1, 2'b00, 3'b000, rs, rt, 5'd0);
  endfunction
  function automatic id_t brn(logic [1:0] t, logic [4:0] rs, logic [4:0] rt);
    return mk(0, 0, 0, 0, 0, 0, t, 3'b110, rs, rt, 5'd0);
  endfunction

  // ---------------- reference model ----------------
  ins_t m_ex = '0, m_mem = '0, m_wb = '0;
  bit   m_valid = 1'b0;

  function automatic ins_t to_ins(id_t w);
    ins_t i;
    i = '{w.alusrc, w.extop, w.memtoreg, w.regwrite, w.memwrite, w.br, w.op, w.rs, w.rt,
          (w.rd_sel ? w.rd : w.rt)};
    return i;
  endfunction

  function automatic logic m_taken(ins_t e, logic z, logic n);
    if (e.br == 2'd1) return z;
    if (e.br == 2'd2) return !z;
    if (e.br == 2'd3) return !z && !n;
    return 1'b0;
  endfunction

  function automatic logic m_load_use(ins_t e, id_t w);
    logic reads_rt;
    reads_rt = w.rd_sel || w.memwrite || (w.br != 2'd0);
    return e.memtoreg && e.regwrite && (e.dst != 0) &&
           ((e.dst == w.rs) || (reads_rt && (e.dst == w.rt)));
  endfunction

  function automatic logic [1:0] m_fwd(ins_t m, ins_t b, logic [4:0] src);
    if (m.regwrite && m.dst != 0 && m.dst == src) return 2'b10;
    if (b.regwrite && b.dst != 0 && b.dst == src) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ex <= '0; m_mem <= '0; m_wb <= '0; m_valid <= 1'b1;
    end else begin
      m_wb  <= m_mem;
      m_mem <= m_ex;
      m_ex  <= (m_taken(m_ex, ex_zero, ex_neg) || m_load_use(m_ex, cur)) ? '0 : to_ins(cur);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic tk;
      tk = m_taken(m_ex, ex_zero, ex_neg);
      chk("m_stall",  {7'd0, stall},  {7'd0, !rst && !tk && m_load_use(m_ex, cur)});
      chk("m_flush",  {7'd0, flush},  {7'd0, !rst && tk});
      chk("m_pc_sel", {7'd0, pc_sel}, {7'd0, !rst && tk});
      chk("m_ex_alusrc", {7'd0, ex_ALUSrc}, {7'd0, m_ex.alusrc});
      chk("m_ex_extop",  {7'd0, ex_ExtOp},  {7'd0, m_ex.extop});
      chk("m_ex_aluop",  {5'd0, ex_ALUop},  {5'd0, m_ex.op});
      chk("m_fwd_a", {6'd0, fwd_a}, {6'd0, m_fwd(m_mem, m_wb, m_ex.rs)});
      chk("m_fwd_b", {6'd0, fwd_b}, {6'd0, m_fwd(m_mem, m_wb, m_ex.rt)});
      chk("m_mem_memwrite", {7'd0, mem_MemWrite}, {7'd0, m_mem.memwrite});
      chk("m_mem_memtoreg", {7'd0, mem_MemtoReg}, {7'd0, m_mem.memtoreg});
      chk("m_wb_regwrite",  {7'd0, wb_RegWrite},  {7'd0, m_wb.regwrite});
      chk("m_wb_memtoreg",  {7'd0, wb_MemtoReg},  {7'd0, m_wb.memtoreg});
      chk("m_wb_dst",       {3'd0, wb_dst},       {3'd0, m_wb.dst});
    end
  end

  // Apply one ID word (plus EX flags and reset) just after an edge, return after the
  // following negedge so the caller can inspect settled outputs.
  task automatic cyc(input id_t w, input logic z = 1'b0, input logic n = 1'b0,
                     input logic r = 1'b0);
    @(posedge clk);
    #1;
    cur = w; ex_zero = z; ex_neg = n; rst = r;
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset and latency
    cyc(nop(), 0, 0, 1);
    cyc(nop(), 0, 0, 1);
    chk("rst_ex_aluop", {5'd0, ex_ALUop}, 8'd0);
    chk("rst_wb_regwrite", {7'd0, wb_RegWrite}, 8'd0);
    chk("rst_stall", {7'd0, stall}, 8'd0);
    cyc(rtype(5'd1, 5'd2, 5'd5));
    cyc(nop());
    chk("lat_ex_aluop", {5'd0, ex_ALUop}, 8'h02);
    cyc(nop());
    cyc(nop());
    chk("lat_wb_regwrite", {7'd0, wb_RegWrite}, 8'd1);
    chk("lat_wb_dst", {3'd0, wb_dst}, 8'd5);

    // Load-use: one stall, bubble, then WB forward
    cyc(lw(5'd1, 5'd8));
    cyc(rtype(5'd8, 5'd2, 5'd9));
    chk("lu_stall", {7'd0, stall}, 8'd1);
    cyc(rtype(5'd8, 5'd2, 5'd9));
    chk("lu_stall_once", {7'd0, stall}, 8'd0);
    chk("lu_bubble_alusrc", {7'd0, ex_ALUSrc}, 8'd0);
    chk("lu_bubble_aluop", {5'd0, ex_ALUop}, 8'd0);
    cyc(nop());
    chk("lu_fwd_a", {6'd0, fwd_a}, 8'd1);
    chk("lu_fwd_b", {6'd0, fwd_b}, 8'd0);
    cyc(lw(5'd1, 5'd8));
    cyc(addi(5'd3, 5'd8));
    chk("lu_addi_no_stall", {7'd0, stall}, 8'd0);
    cyc(nop());

    // Forward priority
    cyc(rtype(5'd1, 5'd2, 5'd3));
    cyc(rtype(5'd3, 5'd3, 5'd3));
    cyc(rtype(5'd3, 5'd3, 5'd4));
    chk("fw_sub_a", {6'd0, fwd_a}, 8'd2);
    chk("fw_sub_b", {6'd0, fwd_b}, 8'd2);
    cyc(nop());
    chk("fw_and_a_mem_wins", {6'd0, fwd_a}, 8'd2);
    chk("fw_and_b_mem_wins", {6'd0, fwd_b}, 8'd2);
    cyc(rtype(5'd1, 5'd2, 5'd0));
    cyc(rtype(5'd0, 5'd0, 5'd6));
    cyc(nop());
    chk("fw_r0_a", {6'd0, fwd_a}, 8'd0);
    chk("fw_r0_b", {6'd0, fwd_b}, 8'd0);

    // Branches
    cyc(brn(2'd1, 5'd1, 5'd2));
    cyc(rtype(5'd1, 5'd2, 5'd7), 1, 0);
    chk("beq_flush", {7'd0, flush}, 8'd1);
    chk("beq_pc_sel", {7'd0, pc_sel}, 8'd1);
    cyc(nop());
    chk("beq_squash_aluop", {5'd0, ex_ALUop}, 8'd0);
    chk("beq_flush_once", {7'd0, flush}, 8'd0);
    cyc(brn(2'd2, 5'd1, 5'd2));
    cyc(nop(), 1, 0);
    chk("bne_not_taken", {7'd0, flush}, 8'd0);
    cyc(brn(2'd3, 5'd1, 5'd0));
    cyc(nop(), 0, 0);
    chk("bgtz_taken", {7'd0, pc_sel}, 8'd1);
    cyc(brn(2'd3, 5'd1, 5'd0));
    cyc(nop(), 0, 1);
    chk("bgtz_neg_not_taken", {7'd0, flush}, 8'd0);

    // Stall and flush on the same cycle: EX word both loads rt=8 and branches
    cyc(mk(0, 0, 1, 1, 0, 0, 2'b01, 3'b000, 5'd1, 5'd8, 5'd0));
    cyc(rtype(5'd8, 5'd2, 5'd9), 1, 0);
    chk("coll_flush", {7'd0, flush}, 8'd1);
    chk("coll_stall", {7'd0, stall}, 8'd0);
    cyc(nop());

    // Reset with sw/lw/R-type in flight
    cyc(sw(5'd1, 5'd2));
    cyc(lw(5'd1, 5'd9));
    cyc(rtype(5'd9, 5'd4, 5'd10), 0, 0, 1);
    chk("mrst_stall_forced", {7'd0, stall}, 8'd0);
    chk("mrst_flush_forced", {7'd0, flush}, 8'd0);
    cyc(nop(), 0, 0, 1);
    chk("mrst_mem_memwrite", {7'd0, mem_MemWrite}, 8'd0);
    chk("mrst_wb_regwrite", {7'd0, wb_RegWrite}, 8'd0);
    chk("mrst_ex_alusrc", {7'd0, ex_ALUSrc}, 8'd0);
    cyc(nop());
    cyc(nop());
    cyc(nop());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer end of the main decoder's control interface: registers the decoded control word through the EX, MEM and WB stages of the 5-stage MIPS pipeline.
- Detects load-use hazards and stalls for them.
- Resolves branches in EX: beq, bne, bgtz.
- Generates ALU operand forwarding selects.
- Sits between the decoder/register file (ID) and the datapath muxes.

Parameters:
- RA_W, 5, register-address width.
- ALUOP_W, 3, width of the ALUop field.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, ExtOp  in  1 each  ID-stage decoder outputs
- Branch  in  2  ID-stage branch type: 00 none, 01 beq, 10 bne, 11 bgtz
- ALUop  in  ALUOP_W  ID-stage ALU op
- id_rs, id_rt, id_rd  in  RA_W each  ID instruction register fields
- ex_zero  in  1  EX ALU result == 0
- ex_neg  in  1  EX ALU result sign bit
- stall  out  1  hold PC and IF/ID this cycle
- flush  out  1  squash IF/ID (branch taken)
- pc_sel  out  1  1 = load branch target
- ex_ALUSrc, ex_ExtOp  out  1 each  EX controls
- ex_ALUop  out  ALUOP_W  EX control
- fwd_a, fwd_b  out  2 each  operand A/B source: 00 regfile, 01 WB result, 10 MEM-stage ALU result
- mem_MemWrite, mem_MemtoReg  out  1 each  MEM controls
- wb_RegWrite, wb_MemtoReg  out  1 each  WB controls
- wb_dst  out  RA_W  write-back register address

Behaviour:
- Reset: on a clk edge with rst=1, all three stage registers become bubbles: every control bit 0, Branch=00, ALUop=0, all rs/rt/dst fields 0.
  - All registered outputs read 0 from the following cycle.
  - While rst=1, stall, flush and pc_sel are forced 0.
  - Reset mid-operation discards in-flight instructions without performing writes.
- Latency: a control word presented in ID at edge N appears at ex_* after N, at mem_* after N+1, and at wb_* after N+2, unless it is bubbled.
- Destination: dst = RegDst ? id_rd : id_rt. It is computed in ID and carried forward. A dst of 0 never counts as a hazard or forward source.
- uses_rt: (RegDst | MemWrite | Branch!=00). Stage EX also holds the rs and rt fields for forwarding.
- Load-use stall (combinational):
  - stall = EX.MemtoReg & EX.RegWrite & EX.dst!=0 & (EX.dst==id_rs | (uses_rt & EX.dst==id_rt)).
  - While stall: ID/EX is loaded with a bubble, and EX->MEM->WB advances normally.
  - The ID inputs are expected to be held by the fetch logic.
  - Exactly 1 stall cycle per hazard, because the load moves to MEM on the next edge.
- Branch resolution in EX (combinational):
  - taken = (EX.Branch==01 & ex_zero) | (10 & !ex_zero) | (11 & !ex_zero & !ex_neg).
  - flush = pc_sel = taken.
  - When taken: ID/EX loads a bubble (the ID instruction is squashed), and the branch itself proceeds to MEM.
- Stall vs. flush on the same cycle: flush wins. stall is forced 0, because the stalled ID instruction is squashed.
- Forwarding, evaluated for EX.rs (fwd_a) and EX.rt (fwd_b):
  - 10 if MEM.RegWrite & MEM.dst!=0 & MEM.dst==src.
  - Otherwise 01 if WB.RegWrite & WB.dst!=0 & WB.dst==src.
  - Otherwise 00.
  - MEM has priority over WB, so the newest value wins.
  - No forwarding for a bubble, since all control bits are 0.
- Stores and branches write no register: their RegWrite=0, so their dst is ignored.
- Outputs are pure registers except stall, flush, pc_sel and fwd_*, which are combinational from stage registers plus ID/EX inputs. These have no combinational loops.

Test Plan:
- Reset/latency: rst=1 for 2 cycles, then present an R-type word (RegDst=1, RegWrite=1, ALUop=3'b010, rd=5) -> all outputs 0 during reset. ex_ALUop=010 after 1 edge; wb_RegWrite=1 and wb_dst=5 after 3 edges.
- Load-use: lw with rt=8 (ALUSrc=1, MemtoReg=1, RegWrite=1, RegDst=0), then R-type with rs=8 -> stall=1 for exactly one cycle. A bubble appears at ex_* (all 0). Next cycle fwd_a=01 for the R-type. No stall if the consumer's only rt use is an immediate op (addi rt=8).
- Forward priority: add $3 followed by sub $3,$3 then and $4,$3,$3 -> sub gets fwd_a=fwd_b=10. Chain with two writers of $3 in MEM and WB -> 10 selected. Writer to $0 -> fwd 00.
- Branches: beq with ex_zero=1 -> flush=pc_sel=1 for one cycle and next ex_* is a bubble. bne with ex_zero=1 -> no flush. bgtz with ex_zero=0, ex_neg=0 -> taken; with ex_neg=1 -> not taken.
- Stall+flush collision: branch taken in EX while a load-use condition is computed for ID -> flush=1, stall=0.
- Reset mid-pipeline: assert rst with sw/lw/R-type in flight -> mem_MemWrite and wb_RegWrite are 0 on the next cycle, and no stall or flush occurs during rst.
